// File: rtl/pulse_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pulse_ctrl_pkg
// Shared constants and helpers for the multi-channel run/stop controller.
//   MODE_TOGGLE / MODE_HOLD : per-channel mode encodings (iMode bit values)
//   BTN_RELEASED            : level of an idle active-low push button
//   next_run()              : run-state update rule for one channel
// -----------------------------------------------------------------------------
package pulse_ctrl_pkg;

    localparam logic MODE_TOGGLE  = 1'b0;
    localparam logic MODE_HOLD    = 1'b1;
    localparam logic BTN_RELEASED = 1'b1;

    // Hold mode runs while the debounced button is low; toggle mode flips on
    // each press event and otherwise keeps its value.
    function automatic logic next_run(input logic i_mode,
                                      input logic i_level,
                                      input logic i_run,
                                      input logic i_press);
        logic w_res;
        if (i_mode == MODE_HOLD) begin
            w_res = ~i_level;
        end else begin
            w_res = i_run ^ i_press;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/pulse_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Two-flop synchronizer, stability counter and press detector for one
// asynchronous active-low push button.
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_btn_n  : raw button (pressed = 0)
//   o_level  : debounced button level (released = 1)
//   o_press  : one-cycle pulse on an accepted 1->0 debounced transition
// A press is only reported once the button has been seen released after
// reset, so a button held through reset must be released and pressed again.
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int DEB_MAX = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_press
);
    import pulse_ctrl_pkg::*;

    localparam int              CW       = $clog2(DEB_MAX + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_MAX - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic          r_armed;
    logic [1:0]    r_vld;
    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_accept;

    // Level disagreement and acceptance once DEB_MAX disagreeing samples seen
    always_comb begin
        w_differ = (r_sync2 != r_level);
        w_accept = w_differ && (r_cnt == CNT_LAST);
    end

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= BTN_RELEASED;
            r_sync2 <= BTN_RELEASED;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce counter, debounced level, press pulse and post-reset arming
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= BTN_RELEASED;
            r_cnt   <= '0;
            r_press <= 1'b0;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt   <= r_cnt + CW'(1);
            end else begin
                r_cnt   <= '0;
            end
            r_press <= w_accept && r_level && r_armed;
            // r_vld marks when the synchronizer holds real samples, not reset fill
            r_vld   <= {r_vld[0], 1'b1};
            r_armed <= r_armed | (r_vld[1] & r_sync2 & r_level);
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/pulse_ctrl.sv
// -----------------------------------------------------------------------------
// pulse_ctrl
// Multi-channel run/stop controller producing one-cycle clock-enable ticks.
//   iClk          : system clock
//   iRst_n        : asynchronous active-low reset
//   iStateTrigger : raw start/stop buttons, active-low, one per channel
//   iStep         : raw single-step buttons, active-low, one per channel
//   iMode         : per-channel mode, 0 = toggle, 1 = hold-to-run
//   iDiv          : shared prescaler divisor, strobe every iDiv+1 cycles
//   oTick         : registered one-cycle enable pulse per channel
//   oRunning      : registered run state per channel
// -----------------------------------------------------------------------------
module pulse_ctrl #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 16,
    parameter int DEB_MAX  = 50000
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic [CHANNELS-1:0] iStateTrigger,
    input  logic [CHANNELS-1:0] iStep,
    input  logic [CHANNELS-1:0] iMode,
    input  logic [DIV_W-1:0]    iDiv,
    output logic [CHANNELS-1:0] oTick,
    output logic [CHANNELS-1:0] oRunning
);
    import pulse_ctrl_pkg::*;

    logic [CHANNELS-1:0] w_trig_level;
    logic [CHANNELS-1:0] w_trig_press;
    logic [CHANNELS-1:0] w_step_level_unused;
    logic [CHANNELS-1:0] w_step_press;

    logic [DIV_W-1:0]    r_cnt;
    logic                w_strobe;
    logic [CHANNELS-1:0] r_run;
    logic [CHANNELS-1:0] r_pend;
    logic [CHANNELS-1:0] w_run_nxt;
    logic [CHANNELS-1:0] w_pend_nxt;
    logic [CHANNELS-1:0] w_tick_nxt;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_btn
        button_debounce #(.DEB_MAX(DEB_MAX)) u_trig (
            .i_clk   (iClk),
            .i_rst_n (iRst_n),
            .i_btn_n (iStateTrigger[g]),
            .o_level (w_trig_level[g]),
            .o_press (w_trig_press[g])
        );
        button_debounce #(.DEB_MAX(DEB_MAX)) u_step (
            .i_clk   (iClk),
            .i_rst_n (iRst_n),
            .i_btn_n (iStep[g]),
            .o_level (w_step_level_unused[g]),
            .o_press (w_step_press[g])
        );
    end

    // Comparing with >= makes a lowered divisor wrap immediately
    always_comb begin
        w_strobe = (r_cnt >= iDiv);
    end

    // Shared prescaler counter
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_cnt <= '0;
        end else if (w_strobe) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    // Per-channel next run, step-pending and tick values
    always_comb begin
        w_run_nxt  = r_run;
        w_pend_nxt = r_pend;
        w_tick_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_tick_nxt[i] = w_strobe && (r_run[i] || r_pend[i]);
            w_run_nxt[i]  = next_run(iMode[i], w_trig_level[i], r_run[i], w_trig_press[i]);
            // Running cancels a pending step; a simultaneous start/stop press
            // discards the step; a pending step is consumed by a strobe.
            if (r_run[i]) begin
                w_pend_nxt[i] = 1'b0;
            end else if (w_step_press[i] && !w_trig_press[i]) begin
                w_pend_nxt[i] = 1'b1;
            end else if (w_strobe) begin
                w_pend_nxt[i] = 1'b0;
            end else begin
                w_pend_nxt[i] = r_pend[i];
            end
        end
    end

    // Run/pending state and registered outputs
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_run    <= '0;
            r_pend   <= '0;
            oTick    <= '0;
            oRunning <= '0;
        end else begin
            r_run    <= w_run_nxt;
            r_pend   <= w_pend_nxt;
            oTick    <= w_tick_nxt;
            oRunning <= r_run;
        end
    end

endmodule

// File: tb/tb_pulse_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pulse_ctrl
// Directed and randomized stimulus for pulse_ctrl (2 channels, DEB_MAX = 4),
// compared every cycle against a behavioural model plus directed checks.
// -----------------------------------------------------------------------------
module tb_pulse_ctrl;

    localparam int CH  = 2;
    localparam int NB  = 2 * CH;
    localparam int DEB = 4;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] trig;
    logic [CH-1:0] step;
    logic [CH-1:0] mode;
    logic [15:0]   div;
    logic [CH-1:0] tick;
    logic [CH-1:0] running;

    int checks;
    int errors;
    int tcnt [CH];

    // Behavioural model state
    int            k;
    int            m_cnt;
    logic          m_level [NB];
    logic          m_armed [NB];
    logic          m_press [NB];
    logic          rq1     [NB];
    logic          rq2     [NB];
    logic          hist    [NB][DEB];
    int            hn      [NB];
    logic          m_run   [CH];
    logic          m_pend  [CH];
    logic [CH-1:0] m_tick;
    logic [CH-1:0] m_orun;

    pulse_ctrl #(.CHANNELS(CH), .DIV_W(16), .DEB_MAX(DEB)) dut (
        .iClk          (clk),
        .iRst_n        (rst_n),
        .iStateTrigger (trig),
        .iStep         (step),
        .iMode         (mode),
        .iDiv          (div),
        .oTick         (tick),
        .oRunning      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        m_cnt = 0;
        m_tick = '0;
        m_orun = '0;
        for (int b = 0; b < NB; b++) begin
            m_level[b] = 1'b1;
            m_armed[b] = 1'b0;
            m_press[b] = 1'b0;
            rq1[b] = 1'b1;
            rq2[b] = 1'b1;
            hn[b] = 0;
            for (int j = 0; j < DEB; j++) hist[b][j] = 1'b1;
        end
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 1'b0;
            m_pend[i] = 1'b0;
        end
    endtask

    // One rising edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        logic [NB-1:0] raw;
        logic [NB-1:0] press_n;
        logic          strobe;
        logic          sync;
        logic          all_diff;
        raw = {step, trig};
        k = k + 1;
        strobe = (m_cnt >= int'(div));
        for (int i = 0; i < CH; i++) begin
            m_tick[i] = strobe && (m_run[i] || m_pend[i]);
            m_orun[i] = m_run[i];
            if (strobe) m_pend[i] = 1'b0;
            if (m_press[CH+i] && !m_run[i] && !m_press[i]) m_pend[i] = 1'b1;
            if (m_run[i]) m_pend[i] = 1'b0;
            if (mode[i]) m_run[i] = !m_level[i];
            else         m_run[i] = m_run[i] ^ m_press[i];
        end
        for (int b = 0; b < NB; b++) begin
            // raw value from two edges ago, released while the synchronizer fills
            sync = (k >= 3) ? rq2[b] : 1'b1;
            rq2[b] = rq1[b];
            rq1[b] = raw[b];
            for (int j = 0; j < DEB - 1; j++) hist[b][j] = hist[b][j+1];
            hist[b][DEB-1] = sync;
            if (hn[b] < DEB) hn[b]++;
            // accept a new level only after DEB consecutive disagreeing samples
            all_diff = (hn[b] == DEB);
            for (int j = 0; j < DEB; j++) if (hist[b][j] == m_level[b]) all_diff = 1'b0;
            press_n[b] = all_diff && m_level[b] && m_armed[b];
            if (k >= 3 && sync && m_level[b]) m_armed[b] = 1'b1;
            if (all_diff) m_level[b] = !m_level[b];
            m_press[b] = press_n[b];
        end
        m_cnt = strobe ? 0 : m_cnt + 1;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("tick", 32'(tick), 32'(m_tick));
        chk("running", 32'(running), 32'(m_orun));
        for (int i = 0; i < CH; i++) tcnt[i] += int'(tick[i]);
    endtask

    task automatic press_trig(input int ch, input int n);
        trig[ch] = 1'b0;
        repeat (n) cyc();
        trig[ch] = 1'b1;
    endtask

    initial begin
        int guard;
        logic [6:0] pat;
        checks = 0;
        errors = 0;
        tcnt[0] = 0;
        tcnt[1] = 0;
        rst_n = 1'b0;
        trig = '1;
        step = '1;
        mode = '0;
        div = 16'd3;
        model_reset();
        #3;
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) cyc();

        // Toggle start: oRunning rises 8 cycles after the press edge
        tcnt[1] = 0;
        trig[0] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            cyc();
            if (n == 7) chk("rise_before_8", 32'(running[0]), 32'd0);
            if (n == 8) chk("rise_at_8", 32'(running[0]), 32'd1);
        end
        trig[0] = 1'b1;
        repeat (8) cyc();
        tcnt[0] = 0;
        repeat (16) cyc();
        chk("ticks_period4", 32'(tcnt[0]), 32'd4);
        press_trig(0, 10);
        repeat (10) cyc();
        tcnt[0] = 0;
        repeat (16) cyc();
        chk("ticks_after_stop", 32'(tcnt[0]), 32'd0);
        chk("ch1_idle_ticks", 32'(tcnt[1]), 32'd0);

        // Bounce rejection on channel 1
        tcnt[1] = 0;
        repeat (5) begin
            trig[1] = 1'b0;
            repeat ($urandom_range(1, 3)) cyc();
            trig[1] = 1'b1;
            repeat ($urandom_range(1, 4)) cyc();
        end
        repeat (10) cyc();
        chk("bounce_running", 32'(running[1]), 32'd0);
        chk("bounce_ticks", 32'(tcnt[1]), 32'd0);

        // Hold mode on channel 0
        mode[0] = 1'b1;
        cyc();
        press_trig(0, 20);
        repeat (8) cyc();
        tcnt[0] = 0;
        repeat (12) cyc();
        chk("hold_ticks_after", 32'(tcnt[0]), 32'd0);
        chk("hold_running_after", 32'(running[0]), 32'd0);
        mode[0] = 1'b0;
        cyc();

        // Single step while stopped: exactly one tick
        tcnt[1] = 0;
        step[1] = 1'b0;
        repeat (6) cyc();
        step[1] = 1'b1;
        repeat (24) cyc();
        chk("step_one_tick", 32'(tcnt[1]), 32'd1);
        // Step while running adds nothing
        press_trig(1, 8);
        repeat (20) cyc();
        tcnt[1] = 0;
        step[1] = 1'b0;
        repeat (6) cyc();
        step[1] = 1'b1;
        repeat (26) cyc();
        chk("step_while_run", 32'(tcnt[1]), 32'd8);
        press_trig(1, 8);
        repeat (12) cyc();
        // Simultaneous start/stop and step press: start wins
        trig[1] = 1'b0;
        step[1] = 1'b0;
        repeat (8) cyc();
        trig[1] = 1'b1;
        step[1] = 1'b1;
        repeat (12) cyc();
        chk("simul_running", 32'(running[1]), 32'd1);
        press_trig(1, 8);
        repeat (12) cyc();

        // Prescaler: iDiv = 0 ticks every cycle
        press_trig(0, 8);
        repeat (10) cyc();
        div = 16'd0;
        repeat (2) cyc();
        tcnt[0] = 0;
        repeat (10) cyc();
        chk("div0_ticks", 32'(tcnt[0]), 32'd10);
        // Lower iDiv from 100 to 2 at cnt = 50
        div = 16'd100;
        guard = 0;
        while (m_cnt != 50 && guard < 200) begin
            cyc();
            guard++;
        end
        chk("cnt50_reached", 32'(m_cnt), 32'd50);
        div = 16'd2;
        pat = 7'b1001001;
        for (int j = 0; j < 7; j++) begin
            cyc();
            chk("div_lower_seq", 32'(tick[0]), 32'(pat[6-j]));
        end

        // Asynchronous reset mid-run with button held through release
        div = 16'd3;
        repeat (4) cyc();
        trig[0] = 1'b0;
        repeat (2) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tick", 32'(tick), 32'd0);
        chk("async_rst_running", 32'(running), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) cyc();
        chk("held_through_reset", 32'(running[0]), 32'd0);
        trig[0] = 1'b1;
        repeat (10) cyc();
        press_trig(0, 8);
        repeat (6) cyc();
        chk("fresh_press_runs", 32'(running[0]), 32'd1);

        // Randomized traffic against the model
        repeat (400) begin
            cyc();
            for (int b = 0; b < CH; b++) begin
                if ($urandom_range(0, 11) == 0) trig[b] = ~trig[b];
                if ($urandom_range(0, 11) == 0) step[b] = ~step[b];
                if ($urandom_range(0, 49) == 0) mode[b] = ~mode[b];
            end
            if ($urandom_range(0, 59) == 0) div = 16'($urandom_range(0, 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
